// File: rtl/fetch_unit_if.sv
// Instruction-memory read port shared by the fetch unit (master) and the memory (slave).
interface fetch_unit_if #(
  parameter int unsigned IMEM_AW = 8
) ();
  logic               imem_req;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic               imem_ack;

  modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ack);
  modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ack);
endinterface

// File: rtl/fetch_unit.sv
// Multicycle-CPU fetch stage: PC register, next-PC selection and IDLE/WAIT instruction fetch.
// Optional macro PC_BOUND_CHECK_EN adds a sticky fault for misaligned / out-of-range PC updates.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IMEM_AW  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        irwrite,
  input  logic        halt,
  input  logic        branch_eq,
  input  logic        branch_ne,
  input  logic        branch_ltz,
  input  logic        jump,
  input  logic        jump_register,
  input  logic        zero,
  input  logic [31:0] rs_data,
  fetch_unit_if.master imem,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        stall,
  output logic        fault
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state;
  logic        fetch_start;
  logic        pc_update;
  logic        branch_taken;
  logic [31:0] branch_off;
  logic [31:0] next_pc;

  assign pc_plus4 = pc + 32'd4;
  assign opcode   = instr[31:26];

  // A fault blocks new fetches; reset overrides any in-flight request.
  assign fetch_start = (state == IDLE) && irwrite && !fault;
  assign pc_update   = !halt && (state == IDLE) && !irwrite;
  assign stall       = !rst && ((state == WAIT) || fetch_start);

  assign imem.imem_req  = stall;
  assign imem.imem_addr = pc[IMEM_AW+1:2];

  assign branch_taken = (branch_eq & zero) | (branch_ne & ~zero) | (branch_ltz & rs_data[31]);
  assign branch_off   = {{14{instr[15]}}, instr[15:0], 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jump_register)     next_pc = rs_data;
    else if (jump)         next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (branch_taken) next_pc = pc_plus4 + branch_off;
  end

`ifdef PC_BOUND_CHECK_EN
  localparam logic [32:0] PC_LIMIT = 33'(33'd4 << IMEM_AW);

  logic fault_q;
  logic pc_bad;

  assign pc_bad = (next_pc[1:0] != 2'b00) || ({1'b0, next_pc} >= PC_LIMIT);
  assign fault  = fault_q;
`else
  assign fault  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
      instr <= '0;
`ifdef PC_BOUND_CHECK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE:    if (fetch_start) state <= WAIT;
        WAIT: begin
          if (imem.imem_ack) begin
            instr <= imem.imem_rdata;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (pc_update) begin
`ifdef PC_BOUND_CHECK_EN
        if (pc_bad) fault_q <= 1'b1;
        else        pc      <= next_pc;
`else
        pc <= next_pc;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected pc/instr updates are queued by stimulus, popped by a monitor.
module tb_fetch_unit;

  localparam int unsigned AW = 8;

  logic        clk = 1'b0;
  logic        rst, irwrite, halt, branch_eq, branch_ne, branch_ltz, jump, jump_register, zero;
  logic [31:0] rs_data;
  logic        ack;
  logic [31:0] rdata;
  logic [31:0] instr, pc, pc_plus4;
  logic [5:0]  opcode;
  logic        stall, fault;

  int total  = 0;
  int passed = 0;

  logic [31:0] pc_q[$];
  logic [31:0] instr_q[$];
  logic        mon_en = 1'b0;
  logic [31:0] prev_pc, prev_instr;

  fetch_unit_if #(.IMEM_AW(AW)) imem ();

  assign imem.imem_ack   = ack;
  assign imem.imem_rdata = rdata;

  fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_AW(AW)) dut (
    .clk(clk), .rst(rst), .irwrite(irwrite), .halt(halt),
    .branch_eq(branch_eq), .branch_ne(branch_ne), .branch_ltz(branch_ltz),
    .jump(jump), .jump_register(jump_register), .zero(zero), .rs_data(rs_data),
    .imem(imem), .instr(instr), .opcode(opcode), .pc(pc), .pc_plus4(pc_plus4),
    .stall(stall), .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every observed change of pc or instr must match the next queued expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (pc !== prev_pc) begin
        if (pc_q.size() == 0) begin
          total++;
          $display("FAIL pc_unexpected: got %h expected no change from %h", pc, prev_pc);
        end else check("pc_update", pc, pc_q.pop_front());
      end
      if (instr !== prev_instr) begin
        if (instr_q.size() == 0) begin
          total++;
          $display("FAIL instr_unexpected: got %h expected no change from %h", instr, prev_instr);
        end else check("instr_load", instr, instr_q.pop_front());
      end
    end
    prev_pc    = pc;
    prev_instr = instr;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pc(input logic [31:0] v);
    pc_q.push_back(v);
    rs_data = v; jump_register = 1'b1; halt = 1'b0;
    tick();
    rs_data = '0; jump_register = 1'b0; halt = 1'b1;
  endtask

  // irwrite held through WAIT (must be ignored there); ack arrives dly cycles after the request.
  task automatic fetch(input logic [31:0] word, input int dly, input logic [31:0] exp_addr);
    int scnt;
    scnt = 0;
    instr_q.push_back(word);
    irwrite = 1'b1;
    @(negedge clk);
    check("req_start", 32'(imem.imem_req), 32'd1);
    check("addr_start", 32'(imem.imem_addr), exp_addr);
    if (stall) scnt++;
    for (int i = 1; i <= dly; i++) begin
      tick();
      if (i == dly) begin irwrite = 1'b0; ack = 1'b1; rdata = word; end
      @(negedge clk);
      if (stall) scnt++;
    end
    check("addr_hold", 32'(imem.imem_addr), exp_addr);
    tick();
    ack = 1'b0; rdata = '0;
    @(negedge clk);
    if (stall) scnt++;
    check("stall_cycles", 32'(scnt), 32'(dly + 1));
    check("req_done", 32'(imem.imem_req), 32'd0);
    tick();
  endtask

  initial begin
    rst = 1'b1; irwrite = 1'b0; halt = 1'b1; branch_eq = 1'b0; branch_ne = 1'b0;
    branch_ltz = 1'b0; jump = 1'b0; jump_register = 1'b0; zero = 1'b0;
    rs_data = '0; ack = 1'b0; rdata = '0;
    tick(); tick();
    @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_req", 32'(imem.imem_req), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    tick();
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // First fetch after reset, memory answers three cycles later.
    fetch(32'h0800_0005, 3, 32'h0);
    check("opcode_j", 32'(opcode), 32'h02);

    // Ack while idle is ignored.
    ack = 1'b1; rdata = 32'hDEAD_BEEF;
    tick();
    ack = 1'b0; rdata = '0;
    @(negedge clk);
    check("idle_ack_ignored", instr, 32'h0800_0005);
    tick();

    // beq with offset -2 words, taken and not taken.
    set_pc(32'h40);
    fetch(32'h1000_FFFE, 1, 32'h10);
    halt = 1'b0; branch_eq = 1'b1; zero = 1'b1; pc_q.push_back(32'h3C);
    tick();
    halt = 1'b1; branch_eq = 1'b0; zero = 1'b0;
    @(negedge clk);
    check("beq_taken", pc, 32'h3C);
    tick();
    set_pc(32'h40);
    halt = 1'b0; branch_eq = 1'b1; zero = 1'b0; pc_q.push_back(32'h44);
    tick();
    halt = 1'b1; branch_eq = 1'b0;
    @(negedge clk);
    check("beq_not_taken", pc, 32'h44);
    tick();

`ifndef PC_BOUND_CHECK_EN
    // Jump keeps pc_plus4[31:28]; jump_register outranks jump.
    set_pc(32'h1000_0010);
    fetch(32'h0800_0040, 2, 32'h04);
    halt = 1'b0; jump = 1'b1; pc_q.push_back(32'h1000_0100);
    tick();
    jump_register = 1'b1; rs_data = 32'h80; pc_q.push_back(32'h80);
    tick();
    jump = 1'b0; jump_register = 1'b0;
    // bltz on negative rs: 0x84 + 0x40*4; then bne with zero=1 falls through.
    branch_ltz = 1'b1; rs_data = 32'h8000_0000; pc_q.push_back(32'h184);
    tick();
    branch_ltz = 1'b0; rs_data = '0; branch_ne = 1'b1; zero = 1'b1; pc_q.push_back(32'h188);
    tick();
    branch_ne = 1'b0; zero = 1'b0; halt = 1'b1;
    @(negedge clk);
    check("jump_chain_pc", pc, 32'h188);

    // Halt freezes pc even with a jump strobe present.
    jump = 1'b1;
    repeat (10) tick();
    jump = 1'b0;
    @(negedge clk);
    check("halt_hold", pc, 32'h188);
    tick();

    // Sequential wrap at the top of the address space.
    set_pc(32'hFFFF_FFFC);
    @(negedge clk);
    check("pc_plus4_wrap", pc_plus4, 32'h0);
    tick();
    halt = 1'b0; pc_q.push_back(32'h0);
    tick();
    halt = 1'b1;
    @(negedge clk);
    check("pc_wrap", pc, 32'h0);
    tick();
`endif

    // Reset during WAIT abandons the fetch; the following ack must not load.
    set_pc(32'h20);
    irwrite = 1'b1;
    tick();
    irwrite = 1'b0;
    tick();
    rst = 1'b1; pc_q.push_back(32'h0); instr_q.push_back(32'h0);
    tick();
    rst = 1'b0; ack = 1'b1; rdata = 32'h1234_5678;
    @(negedge clk);
    check("rst_wait_req", 32'(imem.imem_req), 32'd0);
    tick();
    ack = 1'b0; rdata = '0;
    @(negedge clk);
    check("rst_wait_instr", instr, 32'h0);
    check("rst_wait_pc", pc, 32'h0);
    check("rst_wait_stall", 32'(stall), 32'd0);
    tick();

`ifdef PC_BOUND_CHECK_EN
    // Out-of-range jr target faults, leaves pc alone and blocks later fetches.
    halt = 1'b0; jump_register = 1'b1; rs_data = 32'h400;
    tick();
    halt = 1'b1; jump_register = 1'b0; rs_data = '0;
    @(negedge clk);
    check("bound_fault", 32'(fault), 32'd1);
    check("bound_pc", pc, 32'h0);
    tick();
    irwrite = 1'b1;
    @(negedge clk);
    check("bound_no_req", 32'(imem.imem_req), 32'd0);
    tick();
    irwrite = 1'b0;
    @(negedge clk);
    check("bound_fault_sticky", 32'(fault), 32'd1);
    tick();
`endif

    repeat (2) tick();
    check("pc_queue_drained", 32'(pc_q.size()), 32'd0);
    check("instr_queue_drained", 32'(instr_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter IMEM_AW, 8, instruction-memory word-address width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 irwrite  in  1  from control; request to fetch and latch the instruction at pc.
REQ-006 halt  in  1  from control; 1 = hold PC, 0 = PC update permitted this cycle.
REQ-007 branch_eq, branch_ne, branch_ltz  in  1 each  branch-type strobes from control.
REQ-008 jump, jump_register  in  1 each  jump strobes from control.
REQ-009 zero  in  1  ALU zero flag; rs_data  in  32  register rs value (jr target, bltz sign).
REQ-010 imem_req  out  1  instruction memory read request; imem_addr  out  IMEM_AW  word address.
REQ-011 imem_rdata  in  32  read data; imem_ack  in  1  data valid, one-cycle pulse.
REQ-012 instr  out  32  instruction register; opcode  out  6  equals instr[31:26].
REQ-013 pc  out  32  program counter; pc_plus4  out  32  pc+4, combinational, link address for jal.
REQ-014 stall  out  1  high while a fetch is outstanding; control must freeze its state.
REQ-015 fault  out  1  sticky PC error flag (tied 0 when REQ-029 feature absent).

Function
REQ-016 Fetch FSM SHALL have states IDLE and WAIT.
REQ-017 IDLE with irwrite=1: assert imem_req, imem_addr=pc[IMEM_AW+1:2], go WAIT same edge; stall=1 that cycle.
REQ-018 WAIT: hold imem_req=1 and imem_addr stable until imem_ack; stall=1 throughout.
REQ-019 WAIT with imem_ack=1: instr<=imem_rdata, imem_req<=0, stall<=0, return IDLE; instr updates the edge after ack (latency 1).
REQ-020 imem_ack in IDLE SHALL be ignored; irwrite in WAIT SHALL be ignored.
REQ-021 PC update SHALL occur only when halt=0 and state=IDLE and irwrite=0; otherwise pc holds.
REQ-022 next_pc priority: jump_register -> rs_data; jump -> {pc_plus4[31:28], instr[25:0], 2'b00}; branch taken -> pc_plus4 + (sign_ext(instr[15:0])<<2); else pc_plus4.
REQ-023 branch taken = (branch_eq&zero) | (branch_ne&~zero) | (branch_ltz&rs_data[31]).
REQ-024 All PC arithmetic SHALL be 32-bit modulo 2^32; pc=32'hFFFF_FFFC gives pc_plus4=0.
REQ-025 halt held high (halt opcode) SHALL freeze pc indefinitely; fetches already in WAIT still complete.

Reset
REQ-026 On rst: pc=RESET_PC, instr=0, state=IDLE, imem_req=0, stall=0, fault=0.
REQ-027 rst during WAIT SHALL abandon the fetch; an imem_ack in the reset cycle or after SHALL not load instr.
REQ-028 rst has priority over every other input in the same cycle.

Configuration
REQ-029 Macro PC_BOUND_CHECK_EN: when defined, a PC update whose next_pc[1:0]!=0 or next_pc >= 4*2^IMEM_AW SHALL not load pc, SHALL set fault (sticky until rst), and imem_req SHALL never assert while fault=1.
REQ-030 Without PC_BOUND_CHECK_EN: fault tied 0, next_pc loaded unconditionally, imem_addr uses pc[IMEM_AW+1:2] (upper and low 2 bits ignored).

Verification
REQ-031 Reset then irwrite pulse, memory acks 3 cycles later with 32'h0800_0005 -> imem_addr=0, stall high 4 cycles, instr=32'h0800_0005, opcode=6'b000010.
REQ-032 pc=0x40, instr imm16=16'hFFFE, branch_eq=1, zero=1, halt=0 -> pc=0x3C; same with zero=0 -> pc=0x44.
REQ-033 pc=0x1000_0010, instr[25:0]=26'h000_0040, jump=1 -> pc=0x1000_0100; jump_register=1 with rs_data=0x80 and jump=1 -> pc=0x80.
REQ-034 rst asserted during WAIT, ack arrives next cycle -> instr remains 0, imem_req=0, pc=RESET_PC.
REQ-035 halt=1 for 10 cycles -> pc unchanged; pc=0xFFFF_FFFC, halt=0, no branch -> pc=0 (bound check off).
REQ-036 With PC_BOUND_CHECK_EN, IMEM_AW=8, jump_register to rs_data=0x400 -> fault=1, pc unchanged, subsequent irwrite gives no imem_req.
